fifo_access_arbiter: RTL and testbench
======================================

Name: fifo_access_arbiter

Overview:
- Shares the single push/pop port pair of the FIFO storage controller between two producers and one consumer.
- Grants at most one operation per cycle. Simultaneous push+pop is never issued, because the storage controller treats it as a no-op.
- Tracks its own occupancy so it never pushes past capacity or pops an empty FIFO.
- Round-robin among the producers; alternating priority between push and pop.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 16, storage depth. Usable capacity is DEPTH-1 entries, matching the storage controller's saturation point.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- req0_i  input  1  producer 0 push request.
- data0_i  input  WIDTH  producer 0 write data.
- gnt0_o  output  1  producer 0 grant, one-cycle pulse.
- req1_i  input  1  producer 1 push request.
- data1_i  input  WIDTH  producer 1 write data.
- gnt1_o  output  1  producer 1 grant, one-cycle pulse.
- pop_req_i  input  1  consumer pop request.
- pop_ack_o  output  1  consumer pop acknowledge, one-cycle pulse.
- push_o  output  1  push strobe to storage controller.
- pop_o  output  1  pop strobe to storage controller.
- wdata_o  output  WIDTH  write data to storage.
- occ_o  output  $clog2(DEPTH)  current occupancy, 0..DEPTH-1.
- full_o  output  1  occ_o == DEPTH-1.
- empty_o  output  1  occ_o == 0.

Behaviour:
- Reset (rst_i low, asynchronous):
  - All strobes and grants 0; wdata_o 0; occ_o 0; empty_o 1; full_o 0.
  - rr_ptr = 0 (producer 0 has priority); turn = PUSH.
  - Reset mid-operation drops any pending grant. No strobe is issued in the first cycle after release.
- All outputs are registered.
  - Decision made at edge N from inputs sampled at edge N.
  - gntX_o/push_o/wdata_o or pop_ack_o/pop_o are high during cycle N..N+1. Latency is 1 cycle from sampled request.
- Eligibility at each edge:
  - push_ok = (req0_i | req1_i) & (occ_o != DEPTH-1).
  - pop_ok = pop_req_i & (occ_o != 0).
- Decision FSM per edge: states IDLE, PUSH, POP. The state register holds the operation issued in the current cycle.
  - Neither eligible -> IDLE; all strobes low.
  - Only push_ok -> PUSH.
  - Only pop_ok -> POP.
  - Both eligible -> serve turn; turn then toggles. turn changes only on a contested decision.
- Producer selection on PUSH:
  - Only one requesting -> grant it.
  - Both requesting -> grant producer rr_ptr, then rr_ptr = ~granted index.
  - An uncontested grant also sets rr_ptr = ~granted index.
- PUSH cycle:
  - push_o = 1; matching gntX_o = 1.
  - wdata_o = data of granted producer, captured at the decision edge.
  - occ_o increments at the same edge.
- POP cycle:
  - pop_o = 1; pop_ack_o = 1; occ_o decrements at the same edge.
- Invariants:
  - push_o & pop_o never both 1.
  - gnt0_o & gnt1_o never both 1.
  - gnt0_o | gnt1_o == push_o.
- Requester protocol: hold req and data stable until grant is seen. A req still high during the grant cycle is a new request. Back-to-back grants every cycle are legal.
- Blocked requests:
  - Push request while full is held off with no grant. It is served after the next pop.
  - Pop request while empty is held off with no ack. The pop-side turn is not consumed.
- Occupancy arithmetic: unsigned. It never wraps, because eligibility prevents increment at DEPTH-1 and decrement at 0.
- wdata_o holds its last value in non-PUSH cycles.

Test Plan:
- Reset, then req0_i=1, data0_i=32'hA5A5_0001 for 1 cycle -> one cycle later gnt0_o=1, push_o=1, wdata_o=32'hA5A5_0001, occ_o=1, empty_o=0.
- req0_i and req1_i held high for 4 cycles -> grants alternate 0,1,0,1; occ_o=4; push_o high every cycle.
- Fill to 15 entries, keep req1_i=1 -> full_o=1, no further gnt1_o. Then pop_req_i=1 for one cycle -> pop_o=1 and occ_o=14, followed by gnt1_o=1 and occ_o=15.
- From occ_o=5, hold req0_i and pop_req_i high for 6 cycles -> strictly alternating PUSH,POP,PUSH,POP,PUSH,POP; never push_o & pop_o together; occ_o returns to 5.
- Empty FIFO, pop_req_i=1 for 3 cycles -> pop_ack_o and pop_o stay 0, occ_o=0, empty_o=1.
- Assert rst_i low mid-stream with occ_o=7 and gnt1_o high -> all outputs return to reset values immediately (asynchronously); after release, first request from producer 0 and producer 1 together grants producer 0.

Source files
------------

// File: rtl/fifo_access_arbiter_if.sv
// Handshake bundle between two producers, one consumer and the FIFO access
// arbiter.
//   master : the requester side (producers/consumer). It drives the requests
//            and write data and observes the grants and storage strobes.
//   slave  : the arbiter. It samples the requests and drives the grants, the
//            storage strobes, the write data and the occupancy flags.
interface fifo_access_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int OW = $clog2(DEPTH);

  logic             req0_i;
  logic [WIDTH-1:0] data0_i;
  logic             gnt0_o;
  logic             req1_i;
  logic [WIDTH-1:0] data1_i;
  logic             gnt1_o;
  logic             pop_req_i;
  logic             pop_ack_o;
  logic             push_o;
  logic             pop_o;
  logic [WIDTH-1:0] wdata_o;
  logic [OW-1:0]    occ_o;
  logic             full_o;
  logic             empty_o;

  modport master (
    output req0_i, data0_i, req1_i, data1_i, pop_req_i,
    input  gnt0_o, gnt1_o, pop_ack_o, push_o, pop_o, wdata_o, occ_o, full_o, empty_o
  );

  modport slave (
    input  req0_i, data0_i, req1_i, data1_i, pop_req_i,
    output gnt0_o, gnt1_o, pop_ack_o, push_o, pop_o, wdata_o, occ_o, full_o, empty_o
  );
endinterface

// File: rtl/fifo_access_arbiter.sv
// Shares the single push/pop port pair of a FIFO storage controller between
// two producers and one consumer. At most one operation is issued per cycle
// (push and pop together would be a no-op in the storage controller).
// Producers are served round-robin; a push and a pop that are both eligible
// in the same cycle are served alternately. Occupancy is tracked locally so
// the arbiter never pushes past DEPTH-1 entries or pops an empty FIFO.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active low
//   bus    : slave side of fifo_access_arbiter_if (requests in; grants,
//            push/pop strobes, write data, occupancy, full/empty out)
// Every output is a flop or a decode of flops: the decision taken at edge N
// from inputs sampled at edge N is visible during cycle N..N+1.
module fifo_access_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  fifo_access_arbiter_if.slave bus
);
  localparam int            OW      = $clog2(DEPTH);
  localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH - 1);

  // The state register holds the operation issued in the current cycle.
  typedef enum logic [1:0] {IDLE, PUSH, POP} state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;       // producer with priority on a tie
  logic             turn_q, turn_d;   // 0: push wins a contest, 1: pop wins
  logic             sel_q, sel_d;     // producer granted in this PUSH cycle
  logic [OW-1:0]    occ_q, occ_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             push_ok, pop_ok, pick;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      turn_q  <= 1'b0;
      sel_q   <= 1'b0;
      occ_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      turn_q  <= turn_d;
      sel_q   <= sel_d;
      occ_q   <= occ_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    rr_d    = rr_q;
    turn_d  = turn_q;
    sel_d   = sel_q;
    occ_d   = occ_q;
    wdata_d = wdata_q;

    push_ok = (bus.req0_i | bus.req1_i) & (occ_q != OCC_MAX);
    pop_ok  = bus.pop_req_i & (occ_q != '0);
    // Tie goes to rr_q; otherwise whichever producer is asking.
    pick    = (bus.req0_i & bus.req1_i) ? rr_q : bus.req1_i;

    // turn only moves when push and pop actually contend, so a pop held
    // off by an empty FIFO does not burn the pop side's turn.
    if (push_ok && pop_ok) begin
      state_d = turn_q ? POP : PUSH;
      turn_d  = ~turn_q;
    end else if (push_ok) begin
      state_d = PUSH;
    end else if (pop_ok) begin
      state_d = POP;
    end

    case (state_d)
      PUSH: begin
        sel_d   = pick;
        rr_d    = ~pick;
        occ_d   = occ_q + OW'(1);
        wdata_d = pick ? bus.data1_i : bus.data0_i;
      end
      POP:     occ_d = occ_q - OW'(1);
      default: ;
    endcase
  end

  assign bus.push_o    = (state_q == PUSH);
  assign bus.gnt0_o    = (state_q == PUSH) & ~sel_q;
  assign bus.gnt1_o    = (state_q == PUSH) &  sel_q;
  assign bus.pop_o     = (state_q == POP);
  assign bus.pop_ack_o = (state_q == POP);
  assign bus.wdata_o   = wdata_q;
  assign bus.occ_o     = occ_q;
  assign bus.full_o    = (occ_q == OCC_MAX);
  assign bus.empty_o   = (occ_q == '0);
endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Self-checking bench for fifo_access_arbiter. A reference model keeps the
// FIFO contents as a queue of words (occupancy is its size) and applies the
// arbitration rules directly; every directed and random step is checked
// against it, plus a few literal expectations from the scenarios.
module tb_fifo_access_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  fifo_access_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

  fifo_access_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  logic [WIDTH-1:0] mq[$];
  bit               m_rr;
  bit               m_turn_pop;
  bit               e_push, e_pop, e_g0, e_g1;
  logic [WIDTH-1:0] e_wdata;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr       = 1'b0;
    m_turn_pop = 1'b0;
    e_push     = 1'b0;
    e_pop      = 1'b0;
    e_g0       = 1'b0;
    e_g1       = 1'b0;
    e_wdata    = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".push"},  WIDTH'(bus.push_o),    WIDTH'(e_push));
    chk({tag, ".pop"},   WIDTH'(bus.pop_o),     WIDTH'(e_pop));
    chk({tag, ".ack"},   WIDTH'(bus.pop_ack_o), WIDTH'(e_pop));
    chk({tag, ".gnt0"},  WIDTH'(bus.gnt0_o),    WIDTH'(e_g0));
    chk({tag, ".gnt1"},  WIDTH'(bus.gnt1_o),    WIDTH'(e_g1));
    chk({tag, ".wdata"}, bus.wdata_o,           e_wdata);
    chk({tag, ".occ"},   WIDTH'(bus.occ_o),     WIDTH'(mq.size()));
    chk({tag, ".full"},  WIDTH'(bus.full_o),    WIDTH'(mq.size() == DEPTH - 1));
    chk({tag, ".empty"}, WIDTH'(bus.empty_o),   WIDTH'(mq.size() == 0));
  endtask

  task automatic set_idle();
    bus.req0_i    = 1'b0;
    bus.req1_i    = 1'b0;
    bus.pop_req_i = 1'b0;
    bus.data0_i   = '0;
    bus.data1_i   = '0;
  endtask

  // Drive one cycle of requests, predict the result, check after the edge.
  task automatic step(input bit r0, input logic [WIDTH-1:0] d0, input bit r1,
                      input logic [WIDTH-1:0] d1, input bit pr, input string tag);
    bit pok, qok, do_push, do_pop, who;
    bus.req0_i    = r0;
    bus.data0_i   = d0;
    bus.req1_i    = r1;
    bus.data1_i   = d1;
    bus.pop_req_i = pr;
    pok = (r0 || r1) && (mq.size() != DEPTH - 1);
    qok = pr && (mq.size() != 0);
    if (pok && qok) begin
      do_push    = !m_turn_pop;
      do_pop     = m_turn_pop;
      m_turn_pop = !m_turn_pop;
    end else begin
      do_push = pok;
      do_pop  = qok;
    end
    e_push = do_push;
    e_pop  = do_pop;
    e_g0   = 1'b0;
    e_g1   = 1'b0;
    if (do_push) begin
      who = (r0 && r1) ? m_rr : r1;
      if (who) e_g1 = 1'b1; else e_g0 = 1'b1;
      e_wdata = who ? d1 : d0;
      mq.push_back(e_wdata);
      m_rr = !who;
    end
    if (do_pop) void'(mq.pop_front());
    @(posedge clk_i);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    set_idle();
    rst_i = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    bit prev_push;
    int p0, p1, pp;
    set_idle();

    // 1: single push after reset
    do_reset();
    step(1, 32'hA5A5_0001, 0, 32'h0, 0, "tp1");
    chk("tp1_wdata", bus.wdata_o, 32'hA5A5_0001);
    chk("tp1_occ", WIDTH'(bus.occ_o), 32'd1);
    step(0, 32'h0, 0, 32'h0, 0, "tp1_idle");

    // 2: both producers held -> 0,1,0,1
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, $urandom(), 1, $urandom(), 0, "tp2");
      chk("tp2_g0_order", WIDTH'(bus.gnt0_o), WIDTH'(k % 2 == 0));
    end
    chk("tp2_occ", WIDTH'(bus.occ_o), 32'd4);

    // 3: fill to capacity, then one pop lets producer 1 back in
    while (mq.size() < DEPTH - 1) step(0, 32'h0, 1, $urandom(), 0, "tp3_fill");
    for (int k = 0; k < 2; k++) step(0, 32'h0, 1, $urandom(), 0, "tp3_blocked");
    chk("tp3_full", WIDTH'(bus.full_o), 32'd1);
    step(0, 32'h0, 1, $urandom(), 1, "tp3_pop");
    chk("tp3_pop_occ", WIDTH'(bus.occ_o), 32'd14);
    step(0, 32'h0, 1, $urandom(), 0, "tp3_refill");
    chk("tp3_gnt1", WIDTH'(bus.gnt1_o), 32'd1);
    chk("tp3_occ15", WIDTH'(bus.occ_o), 32'd15);

    // 4: contested push/pop alternates
    do_reset();
    for (int k = 0; k < 5; k++) step(1, $urandom(), 0, 32'h0, 0, "tp4_fill");
    prev_push = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1, $urandom(), 0, 32'h0, 1, "tp4");
      chk("tp4_one_op", WIDTH'(bus.push_o ^ bus.pop_o), 32'd1);
      if (k == 0) chk("tp4_first_push", WIDTH'(bus.push_o), 32'd1);
      else        chk("tp4_alt", WIDTH'(bus.push_o), WIDTH'(!prev_push));
      prev_push = bus.push_o;
    end
    chk("tp4_occ", WIDTH'(bus.occ_o), 32'd5);

    // 5: pop on empty is held off
    do_reset();
    for (int k = 0; k < 3; k++) step(0, 32'h0, 0, 32'h0, 1, "tp5");
    chk("tp5_empty", WIDTH'(bus.empty_o), 32'd1);

    // 6: async reset mid-grant, then tie goes to producer 0
    do_reset();
    for (int k = 0; k < 6; k++) step(1, $urandom(), 0, 32'h0, 0, "tp6_fill");
    step(0, 32'h0, 1, 32'hBEEF_0007, 0, "tp6_g1");
    chk("tp6_g1_hi", WIDTH'(bus.gnt1_o), 32'd1);
    chk("tp6_occ7", WIDTH'(bus.occ_o), 32'd7);
    #2;
    rst_i = 1'b0;
    set_idle();
    model_reset();
    #1;
    check_all("tp6_async");
    @(negedge clk_i);
    rst_i = 1'b1;
    step(1, 32'h1111_0000, 1, 32'h2222_0000, 0, "tp6_after");
    chk("tp6_gnt0_first", WIDTH'(bus.gnt0_o), 32'd1);

    // 7: random traffic in push-heavy, balanced and pop-heavy phases
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (k < 200)      begin p0 = 70; p1 = 60; pp = 20; end
      else if (k < 400) begin p0 = 45; p1 = 45; pp = 50; end
      else              begin p0 = 15; p1 = 15; pp = 80; end
      step($urandom_range(0, 99) < p0, $urandom(), $urandom_range(0, 99) < p1,
           $urandom(), $urandom_range(0, 99) < pp, "rnd");
      chk("rnd_inv_pp", WIDTH'(bus.push_o & bus.pop_o), 32'd0);
      chk("rnd_inv_gnt", WIDTH'(bus.gnt0_o | bus.gnt1_o), WIDTH'(bus.push_o));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
